// File: rtl/conv_layer_sequencer_if.sv
// Control and memory-strobe bundle between the conv layer sequencer and its
// surroundings: layer start/done handshake plus weight, window and output memory ports.
interface conv_layer_sequencer_if #(
    parameter int IN_ADDR_W  = 10,
    parameter int W_ADDR_W   = 8,
    parameter int OUT_ADDR_W = 13
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  w_rd_en;
    logic [W_ADDR_W-1:0]   w_rd_addr;
    logic                  w_load_en;
    logic [4:0]            w_load_idx;
    logic                  in_rd_en;
    logic [IN_ADDR_W-1:0]  in_rd_addr;
    logic                  out_wr_en;
    logic [OUT_ADDR_W-1:0] out_wr_addr;
    logic [2:0]            fmap_idx;

    modport master (
        input  start,
        output busy, done, w_rd_en, w_rd_addr, w_load_en, w_load_idx,
               in_rd_en, in_rd_addr, out_wr_en, out_wr_addr, fmap_idx
    );

    modport slave (
        output start,
        input  busy, done, w_rd_en, w_rd_addr, w_load_en, w_load_idx,
               in_rd_en, in_rd_addr, out_wr_en, out_wr_addr, fmap_idx
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Walks one conv layer: per output fmap, streams 25 weights + bias into the datapath,
// then issues one 5x5 window per cycle and writes results once the datapath latency drains.
module conv_layer_sequencer #(
    parameter int INPUT_WIDTH        = 32,
    parameter int OUTPUT_WIDTH       = 28,
    parameter int OUTPUT_HEIGTH      = 28,
    parameter int OUTPUT_FEATURE_MAP = 6,
    parameter int W_DEPTH            = 26,
    parameter int RD_LATENCY         = 1,
    parameter int PIPE_LATENCY       = 6,
    parameter int IN_ADDR_W          = 10,
    parameter int W_ADDR_W           = 8,
    parameter int OUT_ADDR_W         = 13
) (
    input  logic                   clk,
    input  logic                   rst_n,
    conv_layer_sequencer_if.master bus
);
    localparam int VL = RD_LATENCY + PIPE_LATENCY;
    localparam int CW = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1;
    localparam int RW = (OUTPUT_HEIGTH > 1) ? $clog2(OUTPUT_HEIGTH) : 1;
    localparam logic [CW-1:0]        COL_LAST  = CW'(OUTPUT_WIDTH - 1);
    localparam logic [RW-1:0]        ROW_LAST  = RW'(OUTPUT_HEIGTH - 1);
    localparam logic [4:0]           K_LAST    = 5'(W_DEPTH - 1);
    localparam logic [2:0]           FMAP_LAST = 3'(OUTPUT_FEATURE_MAP - 1);
    localparam logic [IN_ADDR_W-1:0] ROW_STEP  = IN_ADDR_W'(INPUT_WIDTH - OUTPUT_WIDTH + 1);
    localparam logic [VL-1:0]        VP_LAST   = {1'b1, {(VL-1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_LOAD_W = 4'b0010,
        S_CALC   = 4'b0100,
        S_DONE   = 4'b1000
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [4:0]            r_k;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [2:0]            r_fmap;
    logic                  r_issuing;
    logic [VL-1:0]         r_vpipe;
    logic [W_ADDR_W-1:0]   r_w_addr;
    logic [IN_ADDR_W-1:0]  r_in_addr;
    logic [OUT_ADDR_W-1:0] r_out_addr;
    logic                  r_load_en;
    logic [4:0]            r_load_idx;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_w_rd_en;

    logic w_last_k;
    logic w_last_issue;
    logic w_drained;
    logic w_last_fmap;

    assign w_last_k     = (r_k == K_LAST);
    assign w_last_issue = r_issuing && (r_col == COL_LAST) && (r_row == ROW_LAST);
    // The pipe holds one contiguous burst, so "only the top tap set" marks the final write.
    assign w_drained    = !r_issuing && (r_vpipe == VP_LAST);
    assign w_last_fmap  = (r_fmap == FMAP_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next_state = S_LOAD_W; else w_next_state = S_IDLE;
            S_LOAD_W: if (w_last_k)  w_next_state = S_CALC;   else w_next_state = S_LOAD_W;
            S_CALC: begin
                if (w_drained) begin
                    if (w_last_fmap) w_next_state = S_DONE; else w_next_state = S_LOAD_W;
                end else begin
                    w_next_state = S_CALC;
                end
            end
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        w_busy    = 1'b1;
        w_done    = 1'b0;
        w_w_rd_en = 1'b0;
        case (r_state)
            S_IDLE:   w_busy    = 1'b0;
            S_LOAD_W: w_w_rd_en = 1'b1;
            S_CALC:   w_busy    = 1'b1;
            S_DONE:   w_done    = 1'b1;
            default:  w_busy    = 1'b0;
        endcase
    end

    // Counters, address generators and the datapath valid pipe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k        <= 5'd0;
            r_col      <= '0;
            r_row      <= '0;
            r_fmap     <= 3'd0;
            r_issuing  <= 1'b0;
            r_vpipe    <= '0;
            r_w_addr   <= '0;
            r_in_addr  <= '0;
            r_out_addr <= '0;
            r_load_en  <= 1'b0;
            r_load_idx <= 5'd0;
        end else begin
            r_load_en  <= w_w_rd_en;
            r_load_idx <= r_k;
            r_vpipe    <= {r_vpipe[VL-2:0], r_issuing};
            if (bus.out_wr_en) r_out_addr <= r_out_addr + OUT_ADDR_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_fmap     <= 3'd0;
                        r_k        <= 5'd0;
                        r_w_addr   <= '0;
                        r_out_addr <= '0;
                    end
                end
                S_LOAD_W: begin
                    r_w_addr <= r_w_addr + W_ADDR_W'(1);
                    if (w_last_k) begin
                        r_k       <= 5'd0;
                        r_issuing <= 1'b1;
                        r_col     <= '0;
                        r_row     <= '0;
                        r_in_addr <= '0;
                    end else begin
                        r_k <= r_k + 5'd1;
                    end
                end
                S_CALC: begin
                    if (r_issuing) begin
                        if (r_col == COL_LAST) begin
                            r_col     <= '0;
                            r_row     <= r_row + RW'(1);
                            r_in_addr <= r_in_addr + ROW_STEP;
                        end else begin
                            r_col     <= r_col + CW'(1);
                            r_in_addr <= r_in_addr + IN_ADDR_W'(1);
                        end
                        if (w_last_issue) r_issuing <= 1'b0;
                    end
                    if (w_drained && !w_last_fmap) r_fmap <= r_fmap + 3'd1;
                end
                S_DONE: r_k <= 5'd0;
                default: r_k <= 5'd0;
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.w_rd_en     = w_w_rd_en;
    assign bus.w_rd_addr   = r_w_addr;
    assign bus.w_load_en   = r_load_en;
    assign bus.w_load_idx  = r_load_idx;
    assign bus.in_rd_en    = r_issuing;
    assign bus.in_rd_addr  = r_in_addr;
    assign bus.out_wr_en   = r_vpipe[VL-1];
    assign bus.out_wr_addr = r_out_addr;
    assign bus.fmap_idx    = r_fmap;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: a small-geometry instance checked cycle by cycle
// against a timeline model, plus a default-geometry instance run through a full layer.
module tb_conv_layer_sequencer;
    localparam int S_IW = 6, S_OW = 2, S_OH = 2, S_FM = 2;
    localparam int S_WD = 26, S_VL = 7, S_N = S_OW * S_OH;
    localparam int S_P  = S_WD + S_N + S_VL;
    localparam int S_D  = S_FM * S_P + 1;
    localparam int B_N  = 28 * 28;
    localparam int B_TOTAL = 6 * (26 + B_N + 7) + 2;

    typedef struct {
        logic busy; logic done; logic w_en; int w_addr; logic ld_en; int ld_idx;
        logic in_en; int in_addr; logic out_en; int out_addr; int fmap;
    } exp_t;
    typedef struct { int cyc; exp_t e; } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;
    vec_t tbl[18];

    always #5 clk = ~clk;

    conv_layer_sequencer_if #(.IN_ADDR_W(10), .W_ADDR_W(8), .OUT_ADDR_W(13)) s_if ();
    conv_layer_sequencer_if #(.IN_ADDR_W(10), .W_ADDR_W(8), .OUT_ADDR_W(13)) b_if ();

    conv_layer_sequencer #(
        .INPUT_WIDTH(S_IW), .OUTPUT_WIDTH(S_OW), .OUTPUT_HEIGTH(S_OH), .OUTPUT_FEATURE_MAP(S_FM)
    ) u_small (.clk(clk), .rst_n(rst_n), .bus(s_if));

    conv_layer_sequencer u_big (.clk(clk), .rst_n(rst_n), .bus(b_if));

    // Expected small-DUT outputs k cycles after the accepting edge, from the layer timeline.
    function automatic exp_t model(input int k);
        exp_t e;
        int f, o, j;
        e = '{default: 0};
        if (k >= 1 && k <= S_FM * S_P) begin
            f = (k - 1) / S_P;
            o = (k - 1) % S_P;
            e.busy = 1'b1;
            e.fmap = f;
            if (o < S_WD) begin e.w_en = 1'b1; e.w_addr = f * S_WD + o; end
            if (o >= 1 && o <= S_WD) begin e.ld_en = 1'b1; e.ld_idx = o - 1; end
            if (o >= S_WD && o < S_WD + S_N) begin
                j = o - S_WD;
                e.in_en = 1'b1;
                e.in_addr = (j / S_OW) * S_IW + (j % S_OW);
            end
            if (o >= S_WD + S_VL) begin e.out_en = 1'b1; e.out_addr = f * S_N + o - S_WD - S_VL; end
        end else if (k == S_FM * S_P + 1) begin
            e.busy = 1'b1;
            e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic vec_t mk(input int cyc, input bit b, input bit d, input bit we, input int wa,
                                input bit le, input int li, input bit ie, input int ia,
                                input bit oe, input int oa, input int fm);
        vec_t v;
        v.cyc = cyc;
        v.e = '{busy: b, done: d, w_en: we, w_addr: wa, ld_en: le, ld_idx: li,
                in_en: ie, in_addr: ia, out_en: oe, out_addr: oa, fmap: fm};
        return v;
    endfunction

    task automatic check_small(input string name, input exp_t e);
        bit bad;
        bad = 1'b0;
        vec_cnt++;
        if (s_if.busy !== e.busy || s_if.done !== e.done || s_if.w_rd_en !== e.w_en ||
            s_if.w_load_en !== e.ld_en || s_if.in_rd_en !== e.in_en || s_if.out_wr_en !== e.out_en)
            bad = 1'b1;
        if (e.w_en && s_if.w_rd_addr !== 8'(e.w_addr)) bad = 1'b1;
        if (e.ld_en && s_if.w_load_idx !== 5'(e.ld_idx)) bad = 1'b1;
        if (e.in_en && s_if.in_rd_addr !== 10'(e.in_addr)) bad = 1'b1;
        if (e.out_en && s_if.out_wr_addr !== 13'(e.out_addr)) bad = 1'b1;
        if (e.busy && !e.done && s_if.fmap_idx !== 3'(e.fmap)) bad = 1'b1;
        if (bad) begin
            miss_cnt++;
            $display("FAIL %s: got busy=%b done=%b w=%b/%0d ld=%b/%0d in=%b/%0d out=%b/%0d fmap=%0d; want busy=%b done=%b w=%b/%0d ld=%b/%0d in=%b/%0d out=%b/%0d fmap=%0d",
                     name, s_if.busy, s_if.done, s_if.w_rd_en, s_if.w_rd_addr, s_if.w_load_en,
                     s_if.w_load_idx, s_if.in_rd_en, s_if.in_rd_addr, s_if.out_wr_en, s_if.out_wr_addr,
                     s_if.fmap_idx, e.busy, e.done, e.w_en, e.w_addr, e.ld_en, e.ld_idx, e.in_en,
                     e.in_addr, e.out_en, e.out_addr, e.fmap);
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One layer on the small DUT from IDLE, checked every cycle; returns one cycle after DONE.
    task automatic run_small(input string tag, input bit noisy);
        s_if.start = 1'b1;
        for (int k = 1; k <= S_D + 1; k++) begin
            @(negedge clk);
            check_small($sformatf("%s_c%0d", tag, k), model(k));
            if (k < S_D)       s_if.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            else if (k == S_D) s_if.start = noisy;
            else               s_if.start = 1'b0;
        end
    endtask

    initial begin
        int k, stray, n_wr, n_done, bad_order, done_at;
        tbl[0]  = mk(1,  1, 0, 1, 0,  0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(2,  1, 0, 1, 1,  1, 0,  0, 0, 0, 0, 0);
        tbl[2]  = mk(26, 1, 0, 1, 25, 1, 24, 0, 0, 0, 0, 0);
        tbl[3]  = mk(27, 1, 0, 0, 0,  1, 25, 1, 0, 0, 0, 0);
        tbl[4]  = mk(28, 1, 0, 0, 0,  0, 0,  1, 1, 0, 0, 0);
        tbl[5]  = mk(29, 1, 0, 0, 0,  0, 0,  1, 6, 0, 0, 0);
        tbl[6]  = mk(30, 1, 0, 0, 0,  0, 0,  1, 7, 0, 0, 0);
        tbl[7]  = mk(33, 1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0);
        tbl[8]  = mk(34, 1, 0, 0, 0,  0, 0,  0, 0, 1, 0, 0);
        tbl[9]  = mk(37, 1, 0, 0, 0,  0, 0,  0, 0, 1, 3, 0);
        tbl[10] = mk(38, 1, 0, 1, 26, 0, 0,  0, 0, 0, 0, 1);
        tbl[11] = mk(63, 1, 0, 1, 51, 1, 24, 0, 0, 0, 0, 1);
        tbl[12] = mk(64, 1, 0, 0, 0,  1, 25, 1, 0, 0, 0, 1);
        tbl[13] = mk(67, 1, 0, 0, 0,  0, 0,  1, 7, 0, 0, 1);
        tbl[14] = mk(71, 1, 0, 0, 0,  0, 0,  0, 0, 1, 4, 1);
        tbl[15] = mk(74, 1, 0, 0, 0,  0, 0,  0, 0, 1, 7, 1);
        tbl[16] = mk(75, 1, 1, 0, 0,  0, 0,  0, 0, 0, 0, 0);
        tbl[17] = mk(76, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0);

        rst_n = 1'b0;
        s_if.start = 1'b0;
        b_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check_small("reset_state", model(0));
        cmp("reset_w_rd_addr", int'(s_if.w_rd_addr), 0);
        cmp("reset_in_rd_addr", int'(s_if.in_rd_addr), 0);
        cmp("reset_out_wr_addr", int'(s_if.out_wr_addr), 0);
        cmp("reset_fmap", int'(s_if.fmap_idx), 0);
        cmp("big_reset_busy", int'(b_if.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Hand-computed checkpoints for the small geometry
        s_if.start = 1'b1;
        @(negedge clk);
        s_if.start = 1'b0;
        k = 1;
        for (int i = 0; i < 18; i++) begin
            while (k < tbl[i].cyc) begin
                @(negedge clk);
                k++;
            end
            check_small($sformatf("tbl_c%0d", tbl[i].cyc), tbl[i].e);
        end

        run_small("plain", 1'b0);
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_small($sformatf("noisy%0d", r), 1'b1);
        end
        run_small("b2b_a", 1'b0);
        run_small("b2b_b", 1'b0);

        // Reset in the middle of CALCULATION with windows in flight
        s_if.start = 1'b1;
        @(negedge clk);
        s_if.start = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_small("rst_mid_calc", model(0));
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_if.out_wr_en !== 1'b0 || s_if.busy !== 1'b0 || s_if.in_rd_en !== 1'b0) stray++;
        end
        cmp("rst_no_stray_strobes", stray, 0);
        run_small("after_rst", 1'b0);

        // Full default-geometry layer
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        n_wr = 0; n_done = 0; bad_order = 0; done_at = -1;
        for (int c = 1; c <= B_TOTAL + 10; c++) begin
            if (b_if.out_wr_en === 1'b1) begin
                if (b_if.out_wr_addr !== 13'(n_wr)) bad_order++;
                n_wr++;
            end
            if (b_if.done === 1'b1) begin
                n_done++;
                done_at = c;
            end
            @(negedge clk);
        end
        cmp("big_write_count", n_wr, B_N * 6);
        cmp("big_write_order", bad_order, 0);
        cmp("big_done_count", n_done, 1);
        cmp("big_done_cycle", done_at, B_TOTAL - 1);
        cmp("big_busy_after", int'(b_if.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
